// File: rtl/csa_stream_accumulator.sv
// csa_stream_accumulator: streaming carry-save multi-operand adder with chunked final carry-propagate resolve
module csa_stream_accumulator #(
    parameter int BW    = 8,
    parameter int ACC_W = 16,
    parameter int CHUNK = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BW-1:0]    in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);
    localparam int NCH = ACC_W / CHUNK;
    localparam int IW  = NCH > 1 ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {ACC, RESOLVE, OUT} state_t;

    state_t             state, state_nx;
    logic [ACC_W-1:0]   s, c, d, n, res, res_nx;
    logic [CNT_W-1:0]   cnt;
    logic               ovf, carry, acc_fire, out_fire, last_chunk;
    logic [IW-1:0]      idx;
    logic [CHUNK:0]     csum;

    assign d          = ACC_W'(in_data);
    assign n          = (s & c) | (s & d) | (c & d);
    assign acc_fire   = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;
    assign last_chunk = idx == IW'(NCH - 1);
    assign csum       = {1'b0, s[idx*CHUNK +: CHUNK]} + {1'b0, c[idx*CHUNK +: CHUNK]} + (CHUNK+1)'(carry);

    // Result image with the chunk being resolved this cycle merged in
    always_comb begin
        res_nx = res;
        res_nx[idx*CHUNK +: CHUNK] = csum[CHUNK-1:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACC;
        else        state <= state_nx;
    end

    // Next-state: accept until last beat, resolve NCH chunks, hold result until taken
    always_comb begin
        state_nx = state;
        case (state)
            ACC:     state_nx = (acc_fire && in_last) ? RESOLVE : ACC;
            RESOLVE: state_nx = last_chunk ? OUT : RESOLVE;
            OUT:     state_nx = out_ready ? ACC : OUT;
            default: state_nx = ACC;
        endcase
    end

    // Handshake outputs decoded purely from state, so out_ready never bypasses to in_ready
    always_comb begin
        in_ready  = state == ACC;
        out_valid = state == OUT;
    end

    // Carry-save accumulation, chunked resolve and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s         <= '0;
            c         <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            idx       <= '0;
            carry     <= 1'b0;
            res       <= '0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (acc_fire) begin
                s   <= s ^ c ^ d;
                c   <= n << 1;
                ovf <= ovf | n[ACC_W-1];
                cnt <= &cnt ? cnt : cnt + 1'b1;
            end
            if (state == RESOLVE) begin
                res   <= res_nx;
                carry <= last_chunk ? 1'b0 : csum[CHUNK];
                idx   <= last_chunk ? '0 : idx + 1'b1;
                if (last_chunk) begin
                    out_sum   <= res_nx;
                    out_count <= cnt;
                    out_ovf   <= ovf | csum[CHUNK];
                end
            end
            if (out_fire) begin
                s   <= '0;
                c   <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_csa_stream_accumulator.sv
// tb_csa_stream_accumulator: scoreboard bench for the carry-save stream accumulator
module tb_csa_stream_accumulator;
    logic        clk, rst_n, in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
    logic [7:0]  in_data;
    logic [15:0] out_sum, out_count;

    typedef struct {
        logic [15:0] s;
        logic [15:0] n;
        logic        o;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   done;

    csa_stream_accumulator #(.BW(8), .ACC_W(16), .CHUNK(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Compare every delivered result against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out got=%0d exp=none", out_sum);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sum", 32'(out_sum), 32'(e.s));
                chk("count", 32'(out_count), 32'(e.n));
                chk("ovf", 32'(out_ovf), 32'(e.o));
            end
        end
    end

    task automatic send_beat(input logic [7:0] dat, input logic last);
        int t = 0;
        in_valid = 1;
        in_data  = dat;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout got=0 exp=1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_list(input logic [7:0] v[$], input bit expect_out, input bit stall);
        longint sum = 0;
        int     len = v.size();
        foreach (v[i]) sum += v[i];
        if (expect_out) q.push_back('{sum[15:0], 16'(len > 65535 ? 65535 : len), sum >= 65536});
        foreach (v[i]) begin
            send_beat(v[i], i == len - 1);
            if (stall && $urandom_range(0, 3) == 0) begin
                in_valid = 0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while (q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk(tag, 32'(q.size()), 0);
    endtask

    initial begin
        logic [7:0] vq[$];
        int lat;
        rst_n = 0; in_valid = 0; in_data = 0; in_last = 0; out_ready = 1; done = 0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_sum", 32'(out_sum), 0);
        chk("rst_out_count", 32'(out_count), 0);
        chk("rst_out_ovf", 32'(out_ovf), 0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        vq = {8'd1, 8'd2, 8'd3};
        send_list(vq, 1, 0);
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 4);
        chk("rdy_in_out", 32'(in_ready), 0);
        @(posedge clk); #1;
        chk("rdy_after_hs", 32'(in_ready), 1);
        wait_drain("drain_123");

        vq = {};
        repeat (257) vq.push_back(8'd255);
        send_list(vq, 1, 0);
        in_valid = 0;
        wait_drain("drain_257");
        vq.push_back(8'd255);
        send_list(vq, 1, 0);
        in_valid = 0;
        wait_drain("drain_258");

        vq = {8'hA5};
        send_list(vq, 1, 0);
        in_valid = 0;
        wait_drain("drain_a5");

        out_ready = 0;
        vq = {8'd200, 8'd100};
        send_list(vq, 1, 0);
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1; in_data = 8'd7; in_last = 1;
        q.push_back('{16'd7, 16'd1, 1'b0});
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold_sum", 32'(out_sum), 300);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_rdy", 32'(in_ready), 0);
        end
        out_ready = 1;
        @(posedge clk); #1;
        chk("pend_not_taken", 32'(in_ready), 1);
        @(posedge clk); #1;
        chk("pend_taken", 32'(in_ready), 0);
        in_valid = 0;
        wait_drain("drain_hold");

        fork
            begin
                for (int p = 0; p < 20; p++) begin
                    vq = {};
                    repeat ($urandom_range(1, 40)) vq.push_back(8'($urandom));
                    send_list(vq, 1, 1);
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = $urandom_range(0, 3) != 0;
                end
            end
        join
        in_valid = 0;
        out_ready = 1;
        wait_drain("drain_rand");

        vq = {8'd50, 8'd60};
        send_list(vq, 0, 0);
        in_valid = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_rdy", 32'(in_ready), 1);
        chk("abort_sum", 32'(out_sum), 0);
        chk("abort_count", 32'(out_count), 0);
        chk("abort_ovf", 32'(out_ovf), 0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        vq = {8'd9};
        send_list(vq, 1, 0);
        in_valid = 0;
        wait_drain("drain_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/csa_stream_accumulator.md
Name: csa_stream_accumulator

Overview:
- Streaming multi-operand adder: accepts a packet of unsigned BW-bit operands on a valid/ready interface.
- Operands are accumulated in redundant carry-save form, one 3:2 compression per beat, so there is no carry propagation on the input path.
- On the last beat, a chunked carry-propagate adder resolves the total over several cycles and presents it on a valid/ready output with operand count and overflow flag.
- Successor to the single-shot 3:2 + ripple adder; used wherever long operand sums feed downstream arithmetic.

Parameters:
- BW, 8, operand width.
- ACC_W, 16, accumulator/result width; ACC_W >= BW.
- CHUNK, 4, bits resolved per cycle in the final CPA; ACC_W must be a multiple of CHUNK.
- CNT_W, 16, operand counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block accepts operand.
- in_data  input  BW  unsigned operand, zero-extended to ACC_W.
- in_last  input  1  final operand of packet; qualified by in_valid.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  ACC_W  packet sum modulo 2^ACC_W.
- out_count  output  CNT_W  operands in packet, saturating at 2^CNT_W-1.
- out_ovf  output  1  true sum >= 2^ACC_W.

Behaviour:
- Reset (async, rst_n=0): state ACC; S, C, count, ovf, chunk index, carry and result registers cleared. in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0. Deassertion is sampled synchronously.
- States and transitions:
  - ACC: in_ready=1, out_valid=0.
  - RESOLVE: in_ready=0, out_valid=0.
  - OUT: in_ready=0, out_valid=1.
  - ACC -> RESOLVE on an accepted beat with in_last=1.
  - RESOLVE -> OUT after NCH=ACC_W/CHUNK cycles.
  - OUT -> ACC on out_valid & out_ready.
- Accept rule: beat accepted iff in_valid & in_ready at a rising edge.
- Compression per accepted beat, D = zero-extended in_data:
  - S' = S^C^D
  - N = maj(S,C,D)
  - C' = {N[ACC_W-2:0],0}
  - Dropped bit N[ACC_W-1] ORs into sticky ovf.
  - Count increments, saturating.
- Invariant: S + C + 2^ACC_W·(dropped bits) equals the true running sum.
- RESOLVE, chunk j = 0..NCH-1 (LSB first), one per cycle:
  - result[j] = S[j] + C[j] + carry_reg.
  - carry_reg takes the chunk carry-out; carry_reg starts at 0.
  - After the final chunk, ovf |= carry-out.
- Latency: last beat accepted at edge k -> out_valid=1 after edge k+NCH. Example: ACC_W=16, CHUNK=4 gives 4 cycles.
- OUT: out_sum, out_count and out_ovf are held stable until handshake. On handshake, S, C, count and ovf are cleared, and in_ready=1 the following cycle. No same-cycle bypass from out_ready to in_ready.
- Every packet has at least one beat. A single-beat packet (in_last on the first beat) resolves to that operand.
- in_data and in_last are ignored while in_ready=0. Holding in_valid high during RESOLVE/OUT is legal; the beat is accepted after return to ACC.
- out_sum, out_count and out_ovf change only on entry to OUT or on reset. Outside OUT they hold the previous packet's values.
- Reset mid-RESOLVE or mid-OUT aborts the packet. No output is produced for it, and all outputs return to reset values immediately.

Test Plan:
(BW=8, ACC_W=16, CHUNK=4, CNT_W=16)
- Packet 1,2,3 (last on 3), out_ready=1 -> out_valid 4 cycles after last accepted; out_sum=6, out_count=3, out_ovf=0; in_ready high next cycle.
- 257 beats of 255 -> out_sum=65535, out_count=257, out_ovf=0. Then 258 beats of 255 -> out_sum=254, out_count=258, out_ovf=1.
- Single beat 0xA5 with in_last -> out_sum=165, out_count=1, out_ovf=0.
- Packet 200,100 with out_ready low for 10 cycles after out_valid:
  - out_sum=300 held stable; in_ready=0 throughout.
  - A pending in_valid beat of 7 is not accepted until the cycle after the handshake.
  - The next packet 7 alone gives out_sum=7.
- Continuous in_valid with random stalls, 20 packets of random length 1–40 -> each out_sum/out_count matches the reference model; no beats lost or duplicated.
- rst_n pulsed low during the second RESOLVE cycle of packet 50,60 -> outputs zero immediately, in_ready=1. After release, packet 9 yields out_sum=9, out_count=1.
